// File: rtl/calc_op_sequencer_if.sv
// calc_op_sequencer_if: request/result handshake plus the adder-side signals of
// the calculator operation sequencer, bundled so the sequencer and its
// requester share one port.
// master: the requester, which also hosts the shared adder.
// slave : the sequencer itself.
interface calc_op_sequencer_if #(
    parameter int N = 8
);
    logic         start;
    logic [1:0]   op;
    logic [N:0]   a;
    logic [N:0]   b;
    logic         busy;
    logic         done;
    logic [N:0]   result;
    logic         ovf;
    logic [N:0]   add_x;
    logic [N:0]   add_y;
    logic         add_min;
    logic [N:0]   add_res;

    modport master (
        output start, op, a, b, add_res,
        input  busy, done, result, ovf, add_x, add_y, add_min
    );

    modport slave (
        input  start, op, a, b, add_res,
        output busy, done, result, ovf, add_x, add_y, add_min
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: multi-cycle controller for the shared sign-magnitude
// adder/subtractor. It runs add, sub, load and multiply requests and returns a
// normalized sign-magnitude result with a one-cycle done pulse.
// Multiply is repeated addition through the same adder.
// Optional feature macro: CALC_MUL_EN.
// - Defined: multiply is built.
// - Undefined: op 10 finishes immediately with result 0 and ovf 1.
module calc_op_sequencer #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic resetn,
    calc_op_sequencer_if.slave bus
);

`ifdef CALC_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd3
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [N:0] result_q, result_d;
    logic       ovf_q, ovf_d;
    logic [N:0] addX_q, addX_d;
    logic [N:0] addY_q, addY_d;
    logic       addMin_q, addMin_d;

`ifdef CALC_MUL_EN
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         sign_q, sign_d;
    logic [N:0]   mulSum;

    // The overflow test is done on a private N+1-bit sum.
    // It does not trust the adder, whose magnitude wraps silently.
    // addY holds {0,|a|} for the whole multiply, so it supplies |a|.
    assign mulSum = {1'b0, acc_q} + {1'b0, addY_q[N-1:0]};
`endif

    // Zero magnitude always leaves with a positive sign (no -0 result).
    function automatic logic [N:0] normSm(input logic [N:0] v);
        return (v[N-1:0] == '0) ? '0 : v;
    endfunction

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.result  = result_q;
    assign bus.ovf     = ovf_q;
    assign bus.add_x   = addX_q;
    assign bus.add_y   = addY_q;
    assign bus.add_min = addMin_q;

    // Next-state and next-register computation for the sequencer.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        addX_d   = addX_q;
        addY_d   = addY_q;
        addMin_d = addMin_q;
`ifdef CALC_MUL_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        2'b00, 2'b01: begin
                            addX_d   = bus.a;
                            addY_d   = bus.b;
                            addMin_d = bus.op[0];
                            state_d  = EXEC;
                        end
                        2'b11: begin
                            result_d = normSm(bus.a);
                            ovf_d    = 1'b0;
                            state_d  = DONE;
                        end
                        default: begin
`ifdef CALC_MUL_EN
                            if (bus.b[N-1:0] == '0) begin
                                result_d = '0;
                                ovf_d    = 1'b0;
                                state_d  = DONE;
                            end else begin
                                acc_d    = '0;
                                cnt_d    = bus.b[N-1:0];
                                sign_d   = bus.a[N] ^ bus.b[N];
                                addX_d   = '0;
                                addY_d   = {1'b0, bus.a[N-1:0]};
                                addMin_d = 1'b0;
                                state_d  = MUL;
                            end
`else
                            result_d = '0;
                            ovf_d    = 1'b1;
                            state_d  = DONE;
`endif
                        end
                    endcase
                end
            end
            EXEC: begin
                result_d = normSm(bus.add_res);
                ovf_d    = 1'b0;
                state_d  = DONE;
            end
`ifdef CALC_MUL_EN
            MUL: begin
                if (mulSum[N]) begin
                    result_d = {sign_q, {N{1'b1}}};
                    ovf_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    acc_d  = bus.add_res[N-1:0];
                    addX_d = {1'b0, bus.add_res[N-1:0]};
                    cnt_d  = cnt_q - N'(1);
                    if (cnt_q == N'(1)) begin
                        result_d = normSm({sign_q, bus.add_res[N-1:0]});
                        ovf_d    = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    // A low resetn clears everything, even in the middle of an operation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            addX_q   <= '0;
            addY_q   <= '0;
            addMin_q <= 1'b0;
`ifdef CALC_MUL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            addX_q   <= addX_d;
            addY_q   <= addY_d;
            addMin_q <= addMin_d;
`ifdef CALC_MUL_EN
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
`endif
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed and randomized checks of calc_op_sequencer.
// The bench plays the shared sign-magnitude adder.
// It predicts every output from signed integer arithmetic and a latency
// countdown. Follows CALC_MUL_EN the same way the design does.
module tb_calc_op_sequencer;
    localparam int N      = 8;
    localparam int MAXMAG = (1 << N) - 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    calc_op_sequencer_if #(.N(N)) bus ();

    calc_op_sequencer #(.N(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Shared adder stand-in.
    // The equal-magnitude case deliberately returns a negative zero.
    // That way the sequencer's normalization is actually exercised.
    function automatic logic [N:0] smAdd(input logic [N:0] x, input logic [N:0] y, input logic m);
        logic         sx, sy;
        logic [N-1:0] mx, my;
        sx = x[N];
        sy = y[N] ^ m;
        mx = x[N-1:0];
        my = y[N-1:0];
        if (sx == sy) return {sx, mx + my};
        if (mx > my)  return {sx, mx - my};
        return {sy, my - mx};
    endfunction

    assign bus.add_res = smAdd(bus.add_x, bus.add_y, bus.add_min);

    function automatic logic [N:0] toSm(input int v);
        if (v < 0) return {1'b1, N'(-v)};
        return {1'b0, N'(v)};
    endfunction

    // Request outcome from plain arithmetic.
    // Returns: latency to done, result, ovf, and the number of
    // multiply iterations that really accumulate.
    function automatic void predict(input logic [1:0] op, input logic [N:0] a, input logic [N:0] b,
                                    output int lat, output logic [N:0] res, output bit ov,
                                    output int iters);
        int ma, mb, va, vb;
        ma = int'(a[N-1:0]);
        mb = int'(b[N-1:0]);
        va = a[N] ? -ma : ma;
        vb = b[N] ? -mb : mb;
        iters = 0;
        ov    = 1'b0;
        lat   = 1;
        res   = '0;
        case (op)
            2'b00: begin lat = 2; res = toSm(va + vb); end
            2'b01: begin lat = 2; res = toSm(va - vb); end
            2'b11: begin lat = 1; res = toSm(va); end
            default: begin
`ifdef CALC_MUL_EN
                if (mb != 0) begin
                    lat   = mb + 1;
                    iters = mb;
                    res   = toSm((a[N] ^ b[N]) ? -(ma * mb) : ma * mb);
                    for (int k = 1; k <= mb; k++) begin
                        if (k * ma > MAXMAG) begin
                            lat   = k + 1;
                            iters = k - 1;
                            ov    = 1'b1;
                            res   = {a[N] ^ b[N], {N{1'b1}}};
                            break;
                        end
                    end
                end
`else
                ov = 1'b1;
`endif
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model state: what the outputs must be in the current cycle.
    bit         mChk = 1'b0;
    bit         mBusy, mDone, mOvf, mAddMin, pendOvf;
    logic [N:0] mResult, mAddX, mAddY, pendResult;
    int         mRemain, mulLeft, mulMag;

    // Advance the model on each rising edge from the inputs the bench drove.
    always @(posedge clk) begin : modelStep
        int         lat, iters;
        logic [N:0] res;
        bit         ov;
        if (!resetn) begin
            mChk = 1'b1;
            mBusy = 1'b0; mDone = 1'b0; mResult = '0; mOvf = 1'b0;
            mAddX = '0; mAddY = '0; mAddMin = 1'b0;
            mRemain = 0; mulLeft = 0;
        end else if (mChk) begin
            if (mDone) begin
                mDone = 1'b0;
                mBusy = 1'b0;
            end else if (mBusy) begin
                if (mulLeft > 0) begin
                    mAddX = {1'b0, N'(int'(mAddX[N-1:0]) + mulMag)};
                    mulLeft--;
                end
                mRemain--;
                if (mRemain == 0) begin
                    mDone = 1'b1; mResult = pendResult; mOvf = pendOvf;
                end
            end else if (bus.start) begin
                predict(bus.op, bus.a, bus.b, lat, res, ov, iters);
                mBusy = 1'b1;
                if (bus.op[1] == 1'b0) begin
                    mAddX = bus.a; mAddY = bus.b; mAddMin = bus.op[0];
                end
`ifdef CALC_MUL_EN
                if (bus.op == 2'b10 && bus.b[N-1:0] != '0) begin
                    mAddX = '0; mAddY = {1'b0, bus.a[N-1:0]}; mAddMin = 1'b0;
                    mulMag = int'(bus.a[N-1:0]); mulLeft = iters;
                end
`endif
                if (lat == 1) begin
                    mDone = 1'b1; mResult = res; mOvf = ov;
                end else begin
                    mRemain = lat - 1; pendResult = res; pendOvf = ov;
                end
            end
        end
    end

    // Compare every output against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (mChk) begin
            checkOutput("busy",    32'(bus.busy),    32'(mBusy));
            checkOutput("done",    32'(bus.done),    32'(mDone));
            checkOutput("result",  32'(bus.result),  32'(mResult));
            checkOutput("ovf",     32'(bus.ovf),     32'(mOvf));
            checkOutput("add_x",   32'(bus.add_x),   32'(mAddX));
            checkOutput("add_y",   32'(bus.add_y),   32'(mAddY));
            checkOutput("add_min", 32'(bus.add_min), 32'(mAddMin));
        end
    end

    // Presents one request for one edge; returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [1:0] op, input logic [N:0] a, input logic [N:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int fromCyc, output int doneCyc);
        int cyc;
        cyc = fromCyc;
        while (!bus.done && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("doneSeen", 32'(bus.done), 32'd1);
        doneCyc = cyc;
    endtask

    task automatic countDone(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},    32'(bus.busy),    32'd0);
        checkOutput({tag, "_done"},    32'(bus.done),    32'd0);
        checkOutput({tag, "_result"},  32'(bus.result),  32'd0);
        checkOutput({tag, "_ovf"},     32'(bus.ovf),     32'd0);
        checkOutput({tag, "_add_x"},   32'(bus.add_x),   32'd0);
        checkOutput({tag, "_add_y"},   32'(bus.add_y),   32'd0);
        checkOutput({tag, "_add_min"}, 32'(bus.add_min), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dc, pulses;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        resetn = 1'b1;

        // Add: +25 + -40 = -15.
        applyStimulus(2'b00, 9'h019, 9'h128);
        checkOutput("addX_c1", 32'(bus.add_x), 32'h019);
        checkOutput("addY_c1", 32'(bus.add_y), 32'h128);
        checkOutput("addMin_c1", 32'(bus.add_min), 32'd0);
        waitDone(1, dc);
        checkOutput("addDoneCyc", 32'(dc), 32'd2);
        checkOutput("addResult", 32'(bus.result), 32'h10F);
        checkOutput("addOvf", 32'(bus.ovf), 32'd0);

        // Sub to zero must come back as +0.
        applyStimulus(2'b01, 9'h007, 9'h007);
        waitDone(1, dc);
        checkOutput("subDoneCyc", 32'(dc), 32'd2);
        checkOutput("subZero", 32'(bus.result), 32'h000);

        // Mul: -12 x 9.
        applyStimulus(2'b10, 9'h10C, 9'h009);
        waitDone(1, dc);
`ifdef CALC_MUL_EN
        checkOutput("mulDoneCyc", 32'(dc), 32'd10);
        checkOutput("mulResult", 32'(bus.result), 32'h16C);
        checkOutput("mulOvf", 32'(bus.ovf), 32'd0);
`else
        checkOutput("mulOffDoneCyc", 32'(dc), 32'd1);
        checkOutput("mulOffResult", 32'(bus.result), 32'h000);
        checkOutput("mulOffOvf", 32'(bus.ovf), 32'd1);
`endif

        // Mul overflow: 99 x 3 exceeds 255 on the third iteration.
        applyStimulus(2'b10, 9'h063, 9'h003);
        waitDone(1, dc);
`ifdef CALC_MUL_EN
        checkOutput("mulOvDoneCyc", 32'(dc), 32'd4);
        checkOutput("mulOvResult", 32'(bus.result), 32'h0FF);
`else
        checkOutput("mulOvResult", 32'(bus.result), 32'h000);
`endif
        checkOutput("mulOvOvf", 32'(bus.ovf), 32'd1);

        // Mul by zero.
        applyStimulus(2'b10, 9'h032, 9'h000);
        waitDone(1, dc);
        checkOutput("mulZeroDoneCyc", 32'(dc), 32'd1);
        checkOutput("mulZeroResult", 32'(bus.result), 32'h000);

        // Load: -0 normalizes; then a plain negative value.
        applyStimulus(2'b11, 9'h100, 9'h055);
        waitDone(1, dc);
        checkOutput("loadDoneCyc", 32'(dc), 32'd1);
        checkOutput("loadNegZero", 32'(bus.result), 32'h000);
        applyStimulus(2'b11, 9'h1AB, 9'h000);
        waitDone(1, dc);
        checkOutput("loadResult", 32'(bus.result), 32'h1AB);

        // A second start during an add is ignored.
        applyStimulus(2'b00, 9'h005, 9'h003);
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 9'h0FF; bus.b = 9'h1FF;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(2, dc);
        checkOutput("busyIgnDoneCyc", 32'(dc), 32'd2);
        checkOutput("busyIgnResult", 32'(bus.result), 32'h008);
        countDone(6, pulses);
        checkOutput("busyIgnExtraDone", 32'(pulses), 32'd0);

        // Reset during cycle 4 of a 9-iteration multiply.
        applyStimulus(2'b10, 9'h10C, 9'h009);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checkAllZero("midReset");
        countDone(12, pulses);
        checkOutput("midResetNoDone", 32'(pulses), 32'd0);
        applyStimulus(2'b00, 9'h010, 9'h020);
        waitDone(1, dc);
        checkOutput("postResetDoneCyc", 32'(dc), 32'd2);
        checkOutput("postResetResult", 32'(bus.result), 32'h030);

        // Randomized requests with junk starts and operand changes while busy.
        for (int t = 0; t < 250; t++) begin
            logic [1:0]   op;
            logic [N-1:0] ma, mb;
            int           cyc;
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            op = 2'($urandom_range(0, 3));
            if (op == 2'b10) begin
                ma = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 25)) : N'($urandom_range(0, MAXMAG));
                mb = N'($urandom_range(0, 12));
            end else begin
                ma = N'($urandom_range(0, MAXMAG));
                mb = N'($urandom_range(0, MAXMAG - int'(ma)));
            end
            bus.start = 1'b1; bus.op = op;
            bus.a = {1'($urandom_range(0, 1)), ma};
            bus.b = {1'($urandom_range(0, 1)), mb};
            @(negedge clk);
            cyc = 1;
            while (!bus.done && cyc < 600) begin
                bus.start = ($urandom_range(0, 3) == 0);
                bus.op = 2'($urandom_range(0, 3));
                bus.a = 9'($urandom);
                bus.b = 9'($urandom);
                @(negedge clk);
                cyc++;
            end
            bus.start = 1'b0;
            checkOutput("rndDoneSeen", 32'(bus.done), 32'd1);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
